mmio_bus_fabric: RTL
====================

// Module: mmio_bus_fabric
// PURPOSE
//  Parametrised successor to the fixed RAM/IO address decoder: routes CPU data-bus accesses to N_SLOTS
//  memory-mapped targets (data RAM, gpio, counter_timer, uart, gpu, ...) by base/mask match.
//  Adds per-target wait states via a ready handshake, a timeout watchdog, a registered read-data mux and
//  an error/status register block. Sits between the CPU data port and all data-side memories and peripherals.
// PARAMETERS
//  N_SLOTS      4                         number of target slots (1..16)
//  SLOT_BASE    {16'h2000,16'h1000,...}   packed N_SLOTS x 16b base addresses; slot k = bits [16k+15:16k]
//  SLOT_MASK    {16'hF000,16'hFF00,...}   packed N_SLOTS x 16b masks; hit when (address & mask) == base
//  TIMEOUT      15                        max wait cycles before abort (1..255)
//  STATUS_ADDR  16'h10F0                  base of 3-byte status window (STATUS_ADDR..+2)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous, active-high reset
//  address      in   16       CPU data address
//  din          in   8        CPU write data
//  w_en         in   1        CPU write strobe
//  r_en         in   1        CPU read strobe
//  dout         out  8        registered read data to CPU
//  stall        out  1        CPU must hold address/din/strobes while high
//  err_irq      out  1        OR of sticky error flags
//  s_sel        out  N_SLOTS  one-hot target select (valid while access in flight)
//  s_w_en       out  1        write strobe to selected target
//  s_r_en       out  1        read strobe to selected target
//  s_addr       out  16       address pass-through
//  s_din        out  8        write-data pass-through
//  s_rdata      in   8*N      packed target read data, slot k = [8k+7:8k]
//  s_ready      in   N_SLOTS  target k completes the access in the cycle s_ready[k] is high
// BEHAVIOUR
//  Reset: state IDLE, dout=0, stall=0, s_sel=0, s_w_en=s_r_en=0, err flags=0, err_addr=0, last_slot=0.
//  Access = w_en|r_en. Both high -> write; read ignored. Strobe wins over nothing: no strobe -> no activity.
//  Decode priority: status window > lowest-index matching slot > unmapped. Decoder is combinational.
//  IDLE, access to slot k: s_sel[k]=1, s_w_en/s_r_en driven from CPU strobes same cycle.
//   s_ready[k]=1 this cycle -> complete: stall=0; read latches s_rdata[k] into dout at next edge (1-cycle latency).
//   s_ready[k]=0 -> stall=1 combinationally, next state WAIT, wait counter cleared.
//  WAIT: s_sel/strobes held; counter +1 per cycle. s_ready[k]=1 -> complete as above, state IDLE, stall drops
//   same cycle. Counter reaches TIMEOUT with no ready -> ABORT.
//  ABORT (1 cycle): strobes and s_sel low, stall low, dout<=8'hFF if read, err_timeout<=1, err_addr<=address,
//   last_slot<=k, next IDLE. Write is discarded.
//  Unmapped access: completes in IDLE with no stall, no strobes, dout<=8'h00 for read, err_unmapped<=1,
//   err_addr<=address.
//  Status window (handled internally, zero wait): +0 read = {err_timeout,err_unmapped,2'b00,last_slot[3:0]};
//   +1 = err_addr[15:8]; +2 = err_addr[7:0]. Any write to +0 clears both flags; writes to +1/+2 ignored.
//   Clear and new error in the same cycle -> new error wins (flag set).
//  err_irq = err_timeout | err_unmapped, registered.
//  dout holds last completed read value; not altered by writes or idle cycles.
//  Counter width $clog2(TIMEOUT+1); no wrap: saturates path goes to ABORT before overflow.
//  rst asserted in WAIT/ABORT: immediate return to IDLE at edge, stall and strobes low next cycle; target
//   must tolerate strobe loss (same as abort).
//  Back-to-back accesses: a new access may start in the cycle after completion; no dead cycle required.
// STRUCTURE
//  Package mmio_fabric_pkg: state enum (IDLE, WAIT, ABORT), status bit positions, RDATA_UNMAPPED=8'h00,
//   RDATA_TIMEOUT=8'hFF, status offsets.
//  Sub-module mmio_addr_decoder: combinational; address + SLOT_BASE/SLOT_MASK -> hit, one-hot sel, slot index,
//   status_hit. FSM, wait counter, read mux and status regs stay in mmio_bus_fabric.
// TESTING
//  1 zero-wait read slot 0 (s_ready tied high, s_rdata=8'hA5) -> stall never high, dout=8'hA5 one cycle later.
//  2 write slot 1 with s_ready after 3 cycles -> stall high exactly 3 cycles, s_w_en held, err flags stay 0.
//  3 read slot 2, s_ready never -> stall high TIMEOUT cycles, dout=8'hFF, status+0 = 8'h82, err_irq=1.
//  4 read 16'h3000 (unmapped) -> no stall, dout=8'h00, err_addr regs read 8'h30/8'h00; write status+0 -> flags 0.
//  5 overlapping slots 0 and 1 both match -> only s_sel[0]; w_en&r_en together -> s_w_en only.
//  6 rst pulse during WAIT -> next cycle stall=0, s_sel=0, dout=0, state IDLE; following access works.

Source files
------------

// File: rtl/mmio_fabric_pkg.sv
// Shared types and constants for the MMIO bus fabric: FSM states, status-window layout
// and the fixed read-data values returned on failed accesses.
package mmio_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ABORT = 2'd2
   } state_e;

   localparam int SLOT_IDX_W = 4;

   localparam int ST_BIT_TIMEOUT  = 7;
   localparam int ST_BIT_UNMAPPED = 6;

   localparam logic [7:0] RDATA_UNMAPPED = 8'h00;
   localparam logic [7:0] RDATA_TIMEOUT  = 8'hFF;

   localparam logic [1:0] OFS_FLAGS   = 2'd0;
   localparam logic [1:0] OFS_ADDR_HI = 2'd1;
   localparam logic [1:0] OFS_ADDR_LO = 2'd2;

   function automatic logic [7:0] status_flags_byte(input logic                  timeout,
                                                    input logic                  unmapped,
                                                    input logic [SLOT_IDX_W-1:0] last_slot);
      logic [7:0] b;
      b                  = {4'b0000, last_slot};
      b[ST_BIT_TIMEOUT]  = timeout;
      b[ST_BIT_UNMAPPED] = unmapped;
      return b;
   endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational address decoder: status window first, then the lowest-index slot whose
// (address & mask) equals its base.
module mmio_addr_decoder
   import mmio_fabric_pkg::*;
#(
   parameter int                    N_SLOTS     = 4,
   parameter logic [16*N_SLOTS-1:0] SLOT_BASE   = {16'h4000, 16'h2000, 16'h1000, 16'h1800},
   parameter logic [16*N_SLOTS-1:0] SLOT_MASK   = {16'hC000, 16'hF000, 16'hF000, 16'hFF00},
   parameter logic [15:0]           STATUS_ADDR = 16'h10F0
) (
   input  logic [15:0]           address_i,
   output logic                  slot_hit_o,
   output logic [N_SLOTS-1:0]    slot_sel_o,
   output logic [SLOT_IDX_W-1:0] slot_idx_o,
   output logic                  status_hit_o,
   output logic [1:0]            status_ofs_o
);

   logic [15:0]           status_diff;
   logic                  any_match;
   logic [SLOT_IDX_W-1:0] match_idx;

   assign status_diff  = address_i - STATUS_ADDR;
   assign status_hit_o = (status_diff < 16'd3);
   assign status_ofs_o = status_diff[1:0];

   // NOTE: every variable written in an always_comb gets a default first, otherwise
   // paths that skip the assignment infer a latch.
   always_comb begin
      any_match = 1'b0;
      match_idx = '0;
      // Walk downwards so the lowest matching index is the one left standing.
      for (int k = N_SLOTS - 1; k >= 0; k--) begin
         if ((address_i & SLOT_MASK[16*k +: 16]) == SLOT_BASE[16*k +: 16]) begin
            any_match = 1'b1;
            match_idx = SLOT_IDX_W'(k);
         end
      end
   end

   assign slot_hit_o = any_match & ~status_hit_o;
   assign slot_idx_o = match_idx;
   assign slot_sel_o = slot_hit_o ? (N_SLOTS'(1) << match_idx) : '0;

endmodule

// File: rtl/mmio_bus_fabric.sv
// Routes CPU data accesses to N_SLOTS targets with ready-based wait states, a timeout
// abort, a registered read mux and a 3-byte error/status window.
module mmio_bus_fabric
   import mmio_fabric_pkg::*;
#(
   parameter int                    N_SLOTS     = 4,
   parameter logic [16*N_SLOTS-1:0] SLOT_BASE   = {16'h4000, 16'h2000, 16'h1000, 16'h1800},
   parameter logic [16*N_SLOTS-1:0] SLOT_MASK   = {16'hC000, 16'hF000, 16'hF000, 16'hFF00},
   parameter int                    TIMEOUT     = 15,
   parameter logic [15:0]           STATUS_ADDR = 16'h10F0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            address,
   input  logic [7:0]             din,
   input  logic                   w_en,
   input  logic                   r_en,
   output logic [7:0]             dout,
   output logic                   stall,
   output logic                   err_irq,
   output logic [N_SLOTS-1:0]     s_sel,
   output logic                   s_w_en,
   output logic                   s_r_en,
   output logic [15:0]            s_addr,
   output logic [7:0]             s_din,
   input  logic [8*N_SLOTS-1:0]   s_rdata,
   input  logic [N_SLOTS-1:0]     s_ready
);

   localparam int CNT_W    = $clog2(TIMEOUT + 1);
   // Stall cycles so far in WAIT are cnt_q+1 (the IDLE cycle counts); one more unready
   // cycle at cnt_q == ABORT_AT uses up the TIMEOUT budget.
   localparam int ABORT_AT = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [N_SLOTS-1:0]    sel_q, sel_d;
   logic [SLOT_IDX_W-1:0] slot_q, slot_d;
   logic                  wr_q, wr_d;
   logic [7:0]            dout_q, dout_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_unmapped_q, err_unmapped_d;
   logic                  err_irq_q;
   logic [15:0]           err_addr_q, err_addr_d;
   logic [SLOT_IDX_W-1:0] last_slot_q, last_slot_d;

   logic                  dec_hit;
   logic [N_SLOTS-1:0]    dec_sel;
   logic [SLOT_IDX_W-1:0] dec_idx;
   logic                  dec_status;
   logic [1:0]            dec_ofs;

   logic                  access;
   logic                  slot_access;
   logic                  ready_hit;
   logic [7:0]            cur_rdata;
   logic [7:0]            status_rdata;
   logic                  set_timeout, set_unmapped, clear_flags;

   mmio_addr_decoder #(
      .N_SLOTS     (N_SLOTS),
      .SLOT_BASE   (SLOT_BASE),
      .SLOT_MASK   (SLOT_MASK),
      .STATUS_ADDR (STATUS_ADDR)
   ) u_decoder (
      .address_i    (address),
      .slot_hit_o   (dec_hit),
      .slot_sel_o   (dec_sel),
      .slot_idx_o   (dec_idx),
      .status_hit_o (dec_status),
      .status_ofs_o (dec_ofs)
   );

   assign access      = w_en | r_en;
   assign slot_access = access & dec_hit;
   assign ready_hit   = |(s_ready & s_sel);

   always_comb begin
      cur_rdata = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         if (s_sel[k]) cur_rdata = s_rdata[8*k +: 8];
      end
   end

   always_comb begin
      case (dec_ofs)
         OFS_FLAGS:   status_rdata = status_flags_byte(err_timeout_q, err_unmapped_q, last_slot_q);
         OFS_ADDR_HI: status_rdata = err_addr_q[15:8];
         OFS_ADDR_LO: status_rdata = err_addr_q[7:0];
         default:     status_rdata = '0;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (slot_access && !ready_hit) state_d = WAIT;
         WAIT: begin
            if (ready_hit)                        state_d = IDLE;
            else if (cnt_q >= CNT_W'(ABORT_AT))   state_d = ABORT;
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_sel  = '0;
      s_w_en = 1'b0;
      s_r_en = 1'b0;
      stall  = 1'b0;
      case (state_q)
         IDLE: begin
            if (slot_access) begin
               s_sel  = dec_sel;
               s_w_en = w_en;
               s_r_en = ~w_en;
               stall  = ~(|(s_ready & dec_sel));
            end
         end
         WAIT: begin
            s_sel  = sel_q;
            s_w_en = wr_q;
            s_r_en = ~wr_q;
            stall  = ~(|(s_ready & sel_q));
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      slot_d       = slot_q;
      wr_d         = wr_q;
      dout_d       = dout_q;
      err_addr_d   = err_addr_q;
      last_slot_d  = last_slot_q;
      set_timeout  = 1'b0;
      set_unmapped = 1'b0;
      clear_flags  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (slot_access) begin
               sel_d  = dec_sel;
               slot_d = dec_idx;
               wr_d   = w_en;
               if (ready_hit && !w_en) dout_d = cur_rdata;
            end else if (access && dec_status) begin
               if (w_en) clear_flags = (dec_ofs == OFS_FLAGS);
               else      dout_d      = status_rdata;
            end else if (access) begin
               set_unmapped = 1'b1;
               err_addr_d   = address;
               if (!w_en) dout_d = RDATA_UNMAPPED;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ready_hit && !wr_q) dout_d = cur_rdata;
         end
         ABORT: begin
            set_timeout = 1'b1;
            err_addr_d  = address;
            last_slot_d = slot_q;
            if (!wr_q) dout_d = RDATA_TIMEOUT;
         end
         default: ;
      endcase
      // A new error outranks a clear landing in the same cycle.
      err_timeout_d  = set_timeout  | (err_timeout_q  & ~clear_flags);
      err_unmapped_d = set_unmapped | (err_unmapped_q & ~clear_flags);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         sel_q          <= '0;
         slot_q         <= '0;
         wr_q           <= 1'b0;
         dout_q         <= '0;
         err_timeout_q  <= 1'b0;
         err_unmapped_q <= 1'b0;
         err_irq_q      <= 1'b0;
         err_addr_q     <= '0;
         last_slot_q    <= '0;
      end else begin
         cnt_q          <= cnt_d;
         sel_q          <= sel_d;
         slot_q         <= slot_d;
         wr_q           <= wr_d;
         dout_q         <= dout_d;
         err_timeout_q  <= err_timeout_d;
         err_unmapped_q <= err_unmapped_d;
         err_irq_q      <= err_timeout_d | err_unmapped_d;
         err_addr_q     <= err_addr_d;
         last_slot_q    <= last_slot_d;
      end
   end

   assign dout    = dout_q;
   assign err_irq = err_irq_q;
   assign s_addr  = address;
   assign s_din   = din;

endmodule
